fpu_issue_ctrl: RTL
===================

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- LAT_ADD, 2, cycles for fadd/fsub (funct5 00000/00001)
- LAT_MUL, 2, cycles for fmul (00010)
- LAT_DIV, 10, cycles for fdiv (00011)
- LAT_SQRT, 8, cycles for fsqrt (01011)
- LAT_CVT, 2, cycles for fcvt.w.s/fcvt.s.w (11000/11010)
- LAT_MISC, 1, cycles for every other funct5 (sgnj, min/max, compare, fmv)

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge
- rst, in, 1, synchronous active-high reset
- req, in, 1, EX stage holds a valid FP instruction
- flush, in, 1, kill the in-flight FP op (branch/trap redirect)
- op_rd1, in, 32, source operand 1
- op_rd2, in, 32, source operand 2
- op_rm, in, 3, rounding mode
- op_funct5, in, 5, FP operation select
- op_tag, in, 5, destination register index
- fpu_result, in, 32, FPU datapath output
- fpu_rd1, out, 32, operand 1 to FPU, registered
- fpu_rd2, out, 32, operand 2 to FPU, registered
- fpu_rm, out, 3, rounding mode to FPU, registered
- fpu_funct5, out, 5, op select to FPU, registered
- stall, out, 1, freeze IF/ID/EX
- done, out, 1, one-cycle result-valid pulse
- result, out, 32, captured FPU result
- result_tag, out, 5, destination index of result
- busy, out, 1, state is not IDLE

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-004 In IDLE with req=1 and flush=0, the block SHALL latch op_rd1/op_rd2/op_rm/op_funct5/op_tag into the fpu_* and tag registers, load cnt=L-1 (L taken from the latency table by op_funct5), and go to BUSY.
REQ-005 Any funct5 not listed in the table SHALL use LAT_MISC; every latency SHALL be at least 1, and cnt SHALL be 4 bits wide (L at most 16).
REQ-006 In BUSY, fpu_rd1/fpu_rd2/fpu_rm/fpu_funct5 SHALL hold stable.
- cnt>0: decrement cnt.
- cnt==0: register fpu_result into result, go to DONE.
REQ-007 In DONE, done SHALL be 1 and result_tag valid for exactly one cycle; the next state SHALL be IDLE unconditionally, and req seen in DONE SHALL NOT be accepted.
REQ-008 stall SHALL be combinational and equal req & ~flush & (state != DONE).
REQ-009 Timing for an op accepted at edge t:
- operands at FPU from cycle t+1
- result sampled at edge t+L
- done high in cycle t+L+1
- stall high for L+1 cycles
REQ-010 flush=1 in any state SHALL force IDLE at the next edge with no done pulse; flush dominates req; a flush in DONE SHALL still let that cycle's done pulse be seen.
REQ-011 result and result_tag SHALL hold their last values until the next capture.
REQ-012 fpu_* outputs SHALL retain their last values in IDLE; they change only on acceptance.
REQ-013 busy SHALL equal (state != IDLE).

Reset
REQ-014 rst=1 SHALL, at the next edge, set state=IDLE and cnt=0, and clear fpu_rd1/fpu_rd2/result to 0, fpu_rm/fpu_funct5/result_tag to 0, and done/busy to 0; reset dominates flush and req.
REQ-015 Reset asserted during BUSY SHALL abort the op with no done pulse; stall SHALL be 0 while rst=1.

Verification
REQ-016 The bench SHALL cover these directed scenarios (stimulus -> required response):
- fadd: req, funct5=00000, rd1=0x3F800000, rd2=0x40000000, tag=7, model returns 0x40400000 -> stall for 3 cycles, done one cycle later with result=0x40400000, result_tag=7.
- fdiv: funct5=00011 -> fpu_* stable for 10 cycles, done exactly 11 cycles after acceptance, stall low in the done cycle.
- Unknown funct5=11111 -> latency 1: done 2 cycles after acceptance.
- Back-to-back: req held through DONE, second op presented the cycle after -> second op accepted from IDLE, no double issue of the first op, one done per op.
- flush in the 4th BUSY cycle of fdiv -> IDLE next cycle, no done pulse, result unchanged, a new req accepted the following cycle.
- rst mid-BUSY -> all outputs 0 next cycle, no done pulse; with req=1 and rst=1, stall=0.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: latches one FP op, counts its latency,
// captures the FPU result and pulses done for one cycle.
module fpu_issue_ctrl #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 10,
  parameter int LAT_SQRT = 8,
  parameter int LAT_CVT  = 2,
  parameter int LAT_MISC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        flush,
  input  logic [31:0] op_rd1,
  input  logic [31:0] op_rd2,
  input  logic [2:0]  op_rm,
  input  logic [4:0]  op_funct5,
  input  logic [4:0]  op_tag,
  input  logic [31:0] fpu_result,
  output logic [31:0] fpu_rd1,
  output logic [31:0] fpu_rd2,
  output logic [2:0]  fpu_rm,
  output logic [4:0]  fpu_funct5,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  result_tag,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [4:0] tag;
  logic [3:0] lat_m1;

  // cnt is loaded with L-1 so the capture edge lands at t+L
  always_comb begin
    lat_m1 = 4'(LAT_MISC - 1);
    unique case (op_funct5)
      5'b00000,
      5'b00001: lat_m1 = 4'(LAT_ADD - 1);
      5'b00010: lat_m1 = 4'(LAT_MUL - 1);
      5'b00011: lat_m1 = 4'(LAT_DIV - 1);
      5'b01011: lat_m1 = 4'(LAT_SQRT - 1);
      5'b11000,
      5'b11010: lat_m1 = 4'(LAT_CVT - 1);
      default:  lat_m1 = 4'(LAT_MISC - 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      tag        <= 5'd0;
      fpu_rd1    <= 32'd0;
      fpu_rd2    <= 32'd0;
      fpu_rm     <= 3'd0;
      fpu_funct5 <= 5'd0;
      result     <= 32'd0;
      result_tag <= 5'd0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req && !flush) begin
            fpu_rd1    <= op_rd1;
            fpu_rd2    <= op_rd2;
            fpu_rm     <= op_rm;
            fpu_funct5 <= op_funct5;
            tag        <= op_tag;
            cnt        <= lat_m1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            result     <= fpu_result;
            result_tag <= tag;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign stall = ~rst & req & ~flush & (state != DONE);

endmodule
